multi_cycle_controller: RTL and testbench

- Multi-cycle main control FSM for the MIPS datapath (PC, IR, register file, ALU, shared instruction/data memory).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB steps.
- Drives the datapath enables and muxes, and waits on a memory ready handshake.
- Supports add, sub, and, or, addi, ori, beq, j, lw, sw; counts retired instructions.

---
 rtl/multi_cycle_controller_pkg.sv | 58 +++++
 rtl/multi_cycle_controller_if.sv | 44 ++++
 rtl/multi_cycle_controller_alu_decoder.sv | 33 +++
 rtl/multi_cycle_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU codes,
// FSM states and datapath mux selects.
package multi_cycle_controller_pkg;

    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;
    localparam int ALU_OP_W = 4;
    localparam int CNT_W    = 32;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_ORI   = 6'h0d,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25
    } funct_e;

    typedef enum logic [3:0] {
        ALU_AND     = 4'h0,
        ALU_OR      = 4'h1,
        ALU_ADD     = 4'h2,
        ALU_SUB     = 4'h6,
        ALU_DEFAULT = 4'hf
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_e;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and status in, enables and mux selects out.
interface multi_cycle_controller_if
    import multi_cycle_controller_pkg::*;
#(
    parameter int OPCODE_W = multi_cycle_controller_pkg::OPCODE_W,
    parameter int FUNCT_W  = multi_cycle_controller_pkg::FUNCT_W,
    parameter int ALU_OP_W = multi_cycle_controller_pkg::ALU_OP_W,
    parameter int CNT_W    = multi_cycle_controller_pkg::CNT_W
);
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                instr_retired;
    logic [CNT_W-1:0]    instr_count;
    logic                trap;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_retired, instr_count, trap
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_retired, instr_count, trap
    );
endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// Combinational opcode/funct -> ALU operation decode; funct_valid flags unknown R-type functs.
module multi_cycle_controller_alu_decoder
    import multi_cycle_controller_pkg::*;
#(
    parameter int OPCODE_W = multi_cycle_controller_pkg::OPCODE_W,
    parameter int FUNCT_W  = multi_cycle_controller_pkg::FUNCT_W
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [FUNCT_W-1:0]  i_funct,
    output alu_op_e             o_alu_op,
    output logic                o_funct_valid
);

    always_comb begin
        o_alu_op      = ALU_DEFAULT;
        o_funct_valid = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    default: o_funct_valid = 1'b0;
                endcase
            end
            OP_ADDI: o_alu_op = ALU_ADD;
            OP_ORI:  o_alu_op = ALU_OR;
            default: o_alu_op = ALU_DEFAULT;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to send unknown opcodes/functs to a sticky S_TRAP state.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter int OPCODE_W = multi_cycle_controller_pkg::OPCODE_W,
    parameter int FUNCT_W  = multi_cycle_controller_pkg::FUNCT_W,
    parameter int ALU_OP_W = multi_cycle_controller_pkg::ALU_OP_W,
    parameter int CNT_W    = multi_cycle_controller_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multi_cycle_controller_if.master  bus
);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e           r_state;
    state_e           w_next_state;
    logic [CNT_W-1:0] r_instr_count;
    alu_op_e          w_dec_alu_op;
    logic             w_funct_valid;
    alu_op_e          w_alu_op;
    logic             w_pc_write;
    logic             w_pc_write_cond;
    logic [1:0]       w_pc_source;
    logic             w_i_or_d;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_reg_dst;
    logic             w_mem_to_reg;
    logic             w_reg_write;
    logic             w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic             w_retire;
    logic             w_is_rtype;

    multi_cycle_controller_alu_decoder #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W)
    ) u_alu_decoder (
        .i_opcode      (bus.opcode),
        .i_funct       (bus.funct),
        .o_alu_op      (w_dec_alu_op),
        .o_funct_valid (w_funct_valid)
    );

    assign w_is_rtype = (bus.opcode == OP_RTYPE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_source     = PCSRC_ALU;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_RT;
        w_alu_op        = ALU_DEFAULT;
        w_retire        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures the branch target here, ahead of BRANCH.
                w_alu_src_b = SRCB_IMM_SH2;
                w_alu_op    = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE:       w_next_state = (TRAP_EN && !w_funct_valid) ? S_TRAP : S_EXEC;
                    OP_ADDI, OP_ORI: w_next_state = S_EXEC;
                    OP_LW, OP_SW:   w_next_state = S_MEMADR;
                    OP_BEQ:         w_next_state = S_BRANCH;
                    OP_J:           w_next_state = S_JUMP;
                    default:        w_next_state = TRAP_EN ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALU_ADD;
                w_next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = w_is_rtype ? SRCB_RT : SRCB_IMM;
                w_alu_op     = w_dec_alu_op;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = w_is_rtype;
                w_alu_op     = w_dec_alu_op;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = SRCB_RT;
                w_alu_op        = ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_pc_source     = PCSRC_ALUOUT;
                w_retire        = 1'b1;
                w_next_state    = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                w_pc_source  = PCSRC_JUMP;
                w_retire     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_TRAP: begin
                w_next_state = TRAP_EN ? S_TRAP : S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // State-changing enables are gated by rst_n so nothing fires while reset is held.
    assign bus.pc_write      = w_pc_write & rst_n;
    assign bus.pc_write_cond = w_pc_write_cond & rst_n;
    assign bus.ir_write      = w_ir_write & rst_n;
    assign bus.reg_write     = w_reg_write & rst_n;
    assign bus.mem_write     = w_mem_write & rst_n;
    assign bus.instr_retired = w_retire & rst_n;
    assign bus.pc_source     = w_pc_source;
    assign bus.i_or_d        = w_i_or_d;
    assign bus.mem_read      = w_mem_read;
    assign bus.reg_dst       = w_reg_dst;
    assign bus.mem_to_reg    = w_mem_to_reg;
    assign bus.alu_src_a     = w_alu_src_a;
    assign bus.alu_src_b     = w_alu_src_b;
    assign bus.alu_op        = ALU_OP_W'(w_alu_op);
    assign bus.instr_count   = r_instr_count;

`ifdef ILLEGAL_TRAP_EN
    logic r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else if (w_next_state == S_TRAP) begin
            r_trap <= 1'b1;
        end
    end

    assign bus.trap = r_trap;
`else
    assign bus.trap = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: per-cycle control words and retirement counts
// are queued by the driver and checked by an independent negedge monitor.
module tb_multi_cycle_controller;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_ORI  = 6'h0d;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2b;
    localparam logic [5:0] OPC_BAD  = 6'h3f;
    localparam logic [5:0] FN_ADDV  = 6'h20;
    localparam logic [5:0] FN_SUBV  = 6'h22;
    localparam logic [5:0] FN_ANDV  = 6'h24;
    localparam logic [5:0] FN_ORV   = 6'h25;
    localparam logic [5:0] FN_BAD   = 6'h2a;
    localparam logic [3:0] A_AND    = 4'h0;
    localparam logic [3:0] A_OR     = 4'h1;
    localparam logic [3:0] A_ADD    = 4'h2;
    localparam logic [3:0] A_SUB    = 4'h6;
    localparam logic [3:0] A_DEF    = 4'hf;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic [1:0] pcSource;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [3:0] aluOp;
        logic       retired;
        logic       trap;
    } ctrl_t;

    typedef struct {
        ctrl_t c;
        int    step;
    } exp_t;

    logic clk;
    logic rst_n;
    int   assertions;
    int   failures;
    int   stepNo;
    logic [31:0] expCount;
    exp_t        ctrlQ[$];
    logic [31:0] retQ[$];
    exp_t        popped;
    ctrl_t       act;

    multi_cycle_controller_if #(.OPCODE_W(6), .FUNCT_W(6), .ALU_OP_W(4), .CNT_W(32)) bus ();

    multi_cycle_controller #(.OPCODE_W(6), .FUNCT_W(6), .ALU_OP_W(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.instr_retired, bus.trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control words per state, written from the state output tables.
    function automatic ctrl_t cBase();
        ctrl_t c = '0;
        c.aluOp = A_DEF;
        return c;
    endfunction

    function automatic ctrl_t cFetch(input logic rdy);
        ctrl_t c = cBase();
        c.memRead = 1'b1; c.aluSrcB = 2'b01; c.aluOp = A_ADD;
        c.irWrite = rdy;  c.pcWrite = rdy;
        return c;
    endfunction

    function automatic ctrl_t cDecode();
        ctrl_t c = cBase();
        c.aluSrcB = 2'b11; c.aluOp = A_ADD;
        return c;
    endfunction

    function automatic ctrl_t cMemAdr();
        ctrl_t c = cBase();
        c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; c.aluOp = A_ADD;
        return c;
    endfunction

    function automatic ctrl_t cMemRd();
        ctrl_t c = cBase();
        c.memRead = 1'b1; c.iOrD = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cMemWb();
        ctrl_t c = cBase();
        c.regWrite = 1'b1; c.memToReg = 1'b1; c.retired = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cMemWr(input logic rdy);
        ctrl_t c = cBase();
        c.memWrite = 1'b1; c.iOrD = 1'b1; c.retired = rdy;
        return c;
    endfunction

    function automatic ctrl_t cExec(input logic [1:0] srcB, input logic [3:0] op);
        ctrl_t c = cBase();
        c.aluSrcA = 1'b1; c.aluSrcB = srcB; c.aluOp = op;
        return c;
    endfunction

    function automatic ctrl_t cAluWb(input logic rd, input logic [3:0] op);
        ctrl_t c = cBase();
        c.regWrite = 1'b1; c.regDst = rd; c.aluOp = op; c.retired = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cBranch();
        ctrl_t c = cBase();
        c.aluSrcA = 1'b1; c.aluSrcB = 2'b00; c.aluOp = A_SUB;
        c.pcWriteCond = 1'b1; c.pcSource = 2'b01; c.retired = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cJump();
        ctrl_t c = cBase();
        c.pcWrite = 1'b1; c.pcSource = 2'b10; c.retired = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t cTrap();
        ctrl_t c = cBase();
        c.trap = 1'b1;
        return c;
    endfunction

    task automatic checkOutput(input string name, input int step, input ctrl_t got, input ctrl_t exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %05h expected %05h", name, step, got, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One cycle of stimulus: drive inputs, queue the expected outputs, advance to the next cycle.
    task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                                 input logic rdy, input ctrl_t exp);
        exp_t e;
        bus.opcode = opc; bus.funct = fn; bus.zero = z; bus.mem_ready = rdy;
        stepNo++;
        e.c = exp; e.step = stepNo;
        ctrlQ.push_back(e);
        if (exp.retired) begin
            retQ.push_back(expCount);
            expCount = expCount + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("reset_outputs", stepNo, act, cFetch(1'b0));
        checkCount("reset_count", bus.instr_count, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expCount = 32'd0;
    endtask

    task automatic runRType(input logic [5:0] fn, input logic [3:0] op);
        applyStimulus(OPC_R, fn, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_R, fn, 1'b0, 1'b1, cDecode());
        applyStimulus(OPC_R, fn, 1'b0, 1'b1, cExec(2'b00, op));
        applyStimulus(OPC_R, fn, 1'b0, 1'b1, cAluWb(1'b1, op));
    endtask

    task automatic runImm(input logic [5:0] opc, input logic [3:0] op);
        applyStimulus(opc, 6'h11, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(opc, 6'h11, 1'b0, 1'b1, cDecode());
        applyStimulus(opc, 6'h11, 1'b0, 1'b1, cExec(2'b10, op));
        applyStimulus(opc, 6'h11, 1'b0, 1'b1, cAluWb(1'b0, op));
    endtask

    task automatic runLw(input int waits);
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cDecode());
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cMemAdr());
        for (int i = 0; i < waits; i++) applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b0, cMemRd());
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cMemRd());
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cMemWb());
    endtask

    task automatic runSw(input int fetchWaits, input int memWaits);
        for (int i = 0; i < fetchWaits; i++) applyStimulus(OPC_SW, 6'h08, 1'b0, 1'b0, cFetch(1'b0));
        applyStimulus(OPC_SW, 6'h08, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_SW, 6'h08, 1'b0, 1'b1, cDecode());
        applyStimulus(OPC_SW, 6'h08, 1'b0, 1'b1, cMemAdr());
        for (int i = 0; i < memWaits; i++) applyStimulus(OPC_SW, 6'h08, 1'b0, 1'b0, cMemWr(1'b0));
        applyStimulus(OPC_SW, 6'h08, 1'b0, 1'b1, cMemWr(1'b1));
    endtask

    task automatic runBeq(input logic z);
        applyStimulus(OPC_BEQ, 6'h00, z, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_BEQ, 6'h00, z, 1'b1, cDecode());
        applyStimulus(OPC_BEQ, 6'h00, z, 1'b1, cBranch());
    endtask

    task automatic runJ();
        applyStimulus(OPC_J, 6'h10, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_J, 6'h10, 1'b0, 1'b1, cDecode());
        applyStimulus(OPC_J, 6'h10, 1'b0, 1'b1, cJump());
    endtask

    // Monitor: pops one expected word per cycle and checks every retirement against the count queue.
    always @(negedge clk) begin
        if (ctrlQ.size() > 0) begin
            popped = ctrlQ.pop_front();
            checkOutput("ctrl", popped.step, act, popped.c);
        end
        if (bus.instr_retired === 1'b1) begin
            if (retQ.size() == 0) begin
                assertions++;
                failures++;
                $display("[TB] FAIL unexpected_retire: got retire=1 expected retire=0 count=%0d", bus.instr_count);
            end else begin
                checkCount("retire_count", bus.instr_count, retQ.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertions = 0;
        failures   = 0;
        stepNo     = 0;
        expCount   = 32'd0;
        bus.opcode = OPC_R; bus.funct = FN_ADDV; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        doReset();

        // lw interrupted by reset in MEMRD: nothing retires, count stays 0.
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cDecode());
        applyStimulus(OPC_LW, 6'h04, 1'b0, 1'b1, cMemAdr());
        bus.mem_ready = 1'b0;
        stepNo++;
        popped.c = cMemRd(); popped.step = stepNo;
        ctrlQ.push_back(popped);
        @(negedge clk);
        #1;
        doReset();
        checkCount("count_after_mid_reset", bus.instr_count, 32'd0);

        runRType(FN_ADDV, A_ADD);
        runRType(FN_SUBV, A_SUB);
        runRType(FN_ANDV, A_AND);
        runRType(FN_ORV,  A_OR);
        runImm(OPC_ADDI, A_ADD);
        runImm(OPC_ORI,  A_OR);
        runLw(3);
        runBeq(1'b1);
        runBeq(1'b0);
        runJ();
        runSw(0, 0);
        runSw(1, 2);
        checkCount("count_after_sequence", bus.instr_count, 32'd12);

`ifdef ILLEGAL_TRAP_EN
        applyStimulus(OPC_R, FN_BAD, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_R, FN_BAD, 1'b0, 1'b1, cDecode());
        for (int i = 0; i < 3; i++) applyStimulus(OPC_R, FN_BAD, 1'b0, 1'b1, cTrap());
        doReset();
        applyStimulus(OPC_BAD, 6'h00, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_BAD, 6'h00, 1'b0, 1'b1, cDecode());
        for (int i = 0; i < 12; i++) applyStimulus(OPC_BAD, 6'h00, 1'b0, 1'b1, cTrap());
        checkCount("count_after_trap", bus.instr_count, 32'd0);
`else
        runRType(FN_BAD, A_DEF);
        applyStimulus(OPC_BAD, 6'h00, 1'b0, 1'b1, cFetch(1'b1));
        applyStimulus(OPC_BAD, 6'h00, 1'b0, 1'b1, cDecode());
        runRType(FN_ADDV, A_ADD);
        checkCount("count_after_illegal", bus.instr_count, 32'd14);
`endif

        @(posedge clk);
        #1;
        checkCount("ctrl_queue_drained", 32'(ctrlQ.size()), 32'd0);
        checkCount("retire_queue_drained", 32'(retQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
